// File: rtl/acq_trigger_sequencer_if.sv
// -----------------------------------------------------------------------------
// acq_trigger_sequencer_if
// Purpose : bundles the configuration, trigger-channel, FIFO write-port and
//           status signals of the acquisition trigger sequencer.
// Signals :
//   arm, readout_done         level requests from the command domain
//   trigtype[1:0]             0 immediate, 1 rising, 2 falling, 3 external edge
//   lowerthresh/upperthresh   signed 12-bit trigger thresholds
//   lengthtotake[15:0]        FIFO words per event
//   holdoff[15:0]             cycles between readout_done and next arm
//   sample[11:0]              signed trigger-channel sample (registered)
//   ext_trig                  external trigger, clklvds synchronous
//   fifo_wrfull / fifo_wr     FIFO write side full / write strobe
//   wordcount, eventcount     per-event words / completed events
//   event_ready, truncated    status flags
//   seq_state[2:0]            debug state
// Modports: master = configuration/FIFO side, slave = sequencer.
// -----------------------------------------------------------------------------
interface acq_trigger_sequencer_if;
  logic               arm;
  logic               readout_done;
  logic [1:0]         trigtype;
  logic signed [11:0] lowerthresh;
  logic signed [11:0] upperthresh;
  logic [15:0]        lengthtotake;
  logic [15:0]        holdoff;
  logic signed [11:0] sample;
  logic               ext_trig;
  logic               fifo_wrfull;
  logic               fifo_wr;
  logic [15:0]        wordcount;
  logic [15:0]        eventcount;
  logic               event_ready;
  logic               truncated;
  logic [2:0]         seq_state;

  modport master (
    output arm, readout_done, trigtype, lowerthresh, upperthresh,
           lengthtotake, holdoff, sample, ext_trig, fifo_wrfull,
    input  fifo_wr, wordcount, eventcount, event_ready, truncated, seq_state
  );

  modport slave (
    input  arm, readout_done, trigtype, lowerthresh, upperthresh,
           lengthtotake, holdoff, sample, ext_trig, fifo_wrfull,
    output fifo_wr, wordcount, eventcount, event_ready, truncated, seq_state
  );
endinterface

// File: rtl/acq_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// acq_trigger_sequencer
// Purpose : sequences one acquisition in the clklvds domain: waits for arm,
//           evaluates the selected trigger, strobes a programmed number of
//           words into the sample FIFO, then holds the event until readout
//           completes and the holdoff expires.
// Ports   :
//   clklvds  in  sample-rate/2 clock, rising edge
//   rstn     in  asynchronous active-low reset
//   bus      acq_trigger_sequencer_if.slave (config, trigger, FIFO, status)
// Parameters:
//   SYNC_STAGES  synchronizer depth for arm/readout_done (>= 2)
//   TIMEOUT_W    auto-trigger timeout counter width
// Build option:
//   TRIG_TIMEOUT_EN  when defined, a TIMEOUT_W-bit counter runs in ARM1/ARM2
//                    and forces CAPTURE when it reaches all-ones.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// IDLE     | no event; waits for synced arm with synced readout_done low
// ARM1     | armed; waiting for first trigger condition (or ext edge)
// ARM2     | threshold trigger: first crossing seen, waiting for second
// CAPTURE  | strobing fifo_wr until length reached or FIFO full
// DONE     | event held, event_ready high, waiting for readout_done
// HOLDOFF  | counting holdoff cycles before returning to IDLE
// -----------------------------------------------------------------------------
module acq_trigger_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_W   = 24
) (
  input  logic                    clklvds,
  input  logic                    rstn,
  acq_trigger_sequencer_if.slave  bus
);

  if (SYNC_STAGES < 2 || TIMEOUT_W < 1) begin : g_bad_params
    $error("acq_trigger_sequencer: need SYNC_STAGES >= 2 and TIMEOUT_W >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARM1    = 3'd1,
    S_ARM2    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4,
    S_HOLDOFF = 3'd5
  } state_e;

  state_e             state_q, state_d;
  logic [SYNC_STAGES-1:0] arm_sync_q, rdone_sync_q;
  logic               arm_s, rdone_s;
  logic               ext_trig_q, ext_edge;
  logic               auto_trig;

  logic [1:0]         trigtype_q, trigtype_d;
  logic signed [11:0] lower_q, lower_d;
  logic signed [11:0] upper_q, upper_d;
  logic [15:0]        length_q, length_d;
  logic [15:0]        holdoff_q, holdoff_d;
  logic [15:0]        hold_cnt_q, hold_cnt_d;

  logic               fifo_wr_q, fifo_wr_d;
  logic [15:0]        wordcount_q, wordcount_d;
  logic [15:0]        eventcount_q, eventcount_d;
  logic               event_ready_q, event_ready_d;
  logic               truncated_q, truncated_d;

  assign arm_s    = arm_sync_q[SYNC_STAGES-1];
  assign rdone_s  = rdone_sync_q[SYNC_STAGES-1];
  assign ext_edge = bus.ext_trig & ~ext_trig_q;

  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) begin
      arm_sync_q   <= '0;
      rdone_sync_q <= '0;
      ext_trig_q   <= 1'b0;
    end else begin
      arm_sync_q   <= {arm_sync_q[SYNC_STAGES-2:0], bus.arm};
      rdone_sync_q <= {rdone_sync_q[SYNC_STAGES-2:0], bus.readout_done};
      ext_trig_q   <= bus.ext_trig;
    end
  end

`ifdef TRIG_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;

  // Counts across ARM1 and ARM2 together; any exit from the arm states clears it.
  always_comb begin
    tmo_d = '0;
    if ((state_q == S_ARM1 || state_q == S_ARM2) &&
        (state_d == S_ARM1 || state_d == S_ARM2))
      tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end

  assign auto_trig = &tmo_q;
`else
  assign auto_trig = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    trigtype_d   = trigtype_q;
    lower_d      = lower_q;
    upper_d      = upper_q;
    length_d     = length_q;
    holdoff_d    = holdoff_q;
    hold_cnt_d   = hold_cnt_q;
    fifo_wr_d    = 1'b0;
    wordcount_d  = wordcount_q;
    eventcount_d = eventcount_q;
    truncated_d  = truncated_q;

    case (state_q)
      S_IDLE: begin
        wordcount_d = '0;
        truncated_d = 1'b0;
        // A stale readout_done level must not let a held arm re-trigger.
        if (arm_s && !rdone_s) begin
          trigtype_d = bus.trigtype;
          lower_d    = bus.lowerthresh;
          upper_d    = bus.upperthresh;
          length_d   = bus.lengthtotake;
          holdoff_d  = bus.holdoff;
          state_d    = (bus.trigtype == 2'd0) ? S_CAPTURE : S_ARM1;
        end
      end

      S_ARM1: begin
        if (!arm_s) begin
          state_d = S_IDLE;
        end else if (auto_trig) begin
          state_d = S_CAPTURE;
        end else begin
          case (trigtype_q)
            2'd1:    if (bus.sample < lower_q) state_d = S_ARM2;
            2'd2:    if (bus.sample > upper_q) state_d = S_ARM2;
            2'd3:    if (ext_edge)             state_d = S_CAPTURE;
            default: state_d = S_ARM1;
          endcase
        end
      end

      S_ARM2: begin
        if (!arm_s) begin
          state_d = S_IDLE;
        end else if (auto_trig) begin
          state_d = S_CAPTURE;
        end else begin
          case (trigtype_q)
            2'd1:    if (bus.sample > upper_q) state_d = S_CAPTURE;
            2'd2:    if (bus.sample < lower_q) state_d = S_CAPTURE;
            default: state_d = S_ARM2;
          endcase
        end
      end

      S_CAPTURE: begin
        if (wordcount_q == length_q) begin
          eventcount_d = eventcount_q + 16'd1;
          state_d      = S_DONE;
        end else if (bus.fifo_wrfull) begin
          truncated_d  = 1'b1;
          eventcount_d = eventcount_q + 16'd1;
          state_d      = S_DONE;
        end else begin
          fifo_wr_d   = 1'b1;
          wordcount_d = wordcount_q + 16'd1;
        end
      end

      S_DONE: begin
        if (rdone_s) begin
          if (holdoff_q == 16'd0) begin
            state_d = S_IDLE;
          end else begin
            // Terminal count at zero gives exactly holdoff cycles in HOLDOFF.
            hold_cnt_d = holdoff_q - 16'd1;
            state_d    = S_HOLDOFF;
          end
        end
      end

      S_HOLDOFF: begin
        if (hold_cnt_q == 16'd0) state_d = S_IDLE;
        else                     hold_cnt_d = hold_cnt_q - 16'd1;
      end

      default: state_d = S_IDLE;
    endcase

    event_ready_d = (state_q == S_DONE) && (state_d == S_DONE);
  end

  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) begin
      state_q       <= S_IDLE;
      trigtype_q    <= '0;
      lower_q       <= '0;
      upper_q       <= '0;
      length_q      <= '0;
      holdoff_q     <= '0;
      hold_cnt_q    <= '0;
      fifo_wr_q     <= 1'b0;
      wordcount_q   <= '0;
      eventcount_q  <= '0;
      event_ready_q <= 1'b0;
      truncated_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      trigtype_q    <= trigtype_d;
      lower_q       <= lower_d;
      upper_q       <= upper_d;
      length_q      <= length_d;
      holdoff_q     <= holdoff_d;
      hold_cnt_q    <= hold_cnt_d;
      fifo_wr_q     <= fifo_wr_d;
      wordcount_q   <= wordcount_d;
      eventcount_q  <= eventcount_d;
      event_ready_q <= event_ready_d;
      truncated_q   <= truncated_d;
    end
  end

  assign bus.fifo_wr     = fifo_wr_q;
  assign bus.wordcount   = wordcount_q;
  assign bus.eventcount  = eventcount_q;
  assign bus.event_ready = event_ready_q;
  assign bus.truncated   = truncated_q;
  assign bus.seq_state   = state_q;

endmodule

// File: tb/tb_acq_trigger_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acq_trigger_sequencer
// Purpose : directed stimulus for acq_trigger_sequencer; expected per-event
//           results are queued at arm time and checked by a monitor when
//           event_ready rises. Latency/boundary checks are made inline.
// -----------------------------------------------------------------------------
module tb_acq_trigger_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_ARM1 = 3'd1, ST_ARM2 = 3'd2,
                         ST_CAP  = 3'd3, ST_DONE = 3'd4, ST_HOLD = 3'd5;

  logic clklvds = 1'b0;
  logic rstn    = 1'b0;
  always #5 clklvds = ~clklvds;

  acq_trigger_sequencer_if bus();

  acq_trigger_sequencer #(.SYNC_STAGES(2), .TIMEOUT_W(4)) dut (
    .clklvds (clklvds),
    .rstn    (rstn),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clklvds) cyc++;

  typedef struct {
    int wr;
    int runs;
    int wc;
    int ec;
    int tr;
  } exp_t;

  exp_t exp_q[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clklvds);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, input string nm);
    int n;
    n = 0;
    while (bus.seq_state !== st && n < budget) begin
      tick(1);
      n++;
    end
    check(nm, {29'd0, bus.seq_state}, {29'd0, st});
  endtask

  task automatic expect_event(input int wr, input int ec, input int tr);
    exp_t e;
    e.wr   = wr;
    e.runs = (wr > 0) ? 1 : 0;
    e.wc   = wr;
    e.ec   = ec;
    e.tr   = tr;
    exp_q.push_back(e);
  endtask

  task automatic finish_event(input int budget);
    bus.arm          = 1'b0;
    bus.readout_done = 1'b1;
    wait_state(ST_IDLE, budget, "readout_to_idle");
    check("event_ready_low_after_done", {31'd0, bus.event_ready}, 32'd0);
    bus.readout_done = 1'b0;
    tick(4);
  endtask

  // Monitor: counts write strobes per event and scores each event when
  // event_ready rises.
  int   mon_wr   = 0;
  int   mon_runs = 0;
  logic prev_wr  = 1'b0;
  logic prev_er  = 1'b0;
  exp_t mon_e;

  always @(negedge clklvds) begin
    if (!rstn) begin
      mon_wr   = 0;
      mon_runs = 0;
      prev_wr  = 1'b0;
      prev_er  = 1'b0;
    end else begin
      if (bus.fifo_wr === 1'b1) begin
        mon_wr++;
        if (!prev_wr) mon_runs++;
      end
      prev_wr = (bus.fifo_wr === 1'b1);
      if (bus.event_ready === 1'b1 && !prev_er) begin
        check("event_was_expected", {31'd0, exp_q.size() > 0}, 32'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          check("ev_wr_strobes", mon_wr, mon_e.wr);
          check("ev_wr_runs", mon_runs, mon_e.runs);
          check("ev_wordcount", {16'd0, bus.wordcount}, mon_e.wc);
          check("ev_eventcount", {16'd0, bus.eventcount}, mon_e.ec);
          check("ev_truncated", {31'd0, bus.truncated}, mon_e.tr);
        end
        mon_wr   = 0;
        mon_runs = 0;
      end
      prev_er = (bus.event_ready === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, k, r_cyc, d_cyc;

    bus.arm          = 1'b0;
    bus.readout_done = 1'b0;
    bus.trigtype     = 2'd0;
    bus.lowerthresh  = 12'sd0;
    bus.upperthresh  = 12'sd0;
    bus.lengthtotake = 16'd0;
    bus.holdoff      = 16'd0;
    bus.sample       = 12'sd0;
    bus.ext_trig     = 1'b0;
    bus.fifo_wrfull  = 1'b0;

    // Reset values
    tick(3);
    check("rst_seq_state", {29'd0, bus.seq_state}, 32'd0);
    check("rst_fifo_wr", {31'd0, bus.fifo_wr}, 32'd0);
    check("rst_wordcount", {16'd0, bus.wordcount}, 32'd0);
    check("rst_eventcount", {16'd0, bus.eventcount}, 32'd0);
    check("rst_event_ready", {31'd0, bus.event_ready}, 32'd0);
    check("rst_truncated", {31'd0, bus.truncated}, 32'd0);
    rstn = 1'b1;
    tick(2);

    // Immediate trigger, 100 words
    bus.trigtype     = 2'd0;
    bus.lengthtotake = 16'd100;
    bus.holdoff      = 16'd0;
    expect_event(100, 1, 0);
    bus.arm = 1'b1;
    wait_state(ST_DONE, 200, "t0_reach_done");
    check("t0_event_ready_lags_done", {31'd0, bus.event_ready}, 32'd0);
    tick(1);
    check("t0_event_ready_next", {31'd0, bus.event_ready}, 32'd1);
    finish_event(20);

    // Rising threshold: equality never triggers, strict crossings do
    bus.trigtype     = 2'd1;
    bus.lowerthresh  = -12'sd10;
    bus.upperthresh  = 12'sd10;
    bus.lengthtotake = 16'd5;
    bus.sample       = 12'sd0;
    expect_event(5, 2, 0);
    bus.arm = 1'b1;
    wait_state(ST_ARM1, 10, "t1_reach_arm1");
    bus.sample = -12'sd10;
    tick(5);
    check("t1_eq_lower_stays_arm1", {29'd0, bus.seq_state}, {29'd0, ST_ARM1});
    bus.sample = 12'sd10;
    tick(3);
    check("t1_eq_upper_stays_arm1", {29'd0, bus.seq_state}, {29'd0, ST_ARM1});
    bus.sample = -12'sd11;
    tick(1);
    check("t1_below_lower_arm2", {29'd0, bus.seq_state}, {29'd0, ST_ARM2});
    bus.sample = 12'sd10;
    tick(3);
    check("t1_eq_upper_stays_arm2", {29'd0, bus.seq_state}, {29'd0, ST_ARM2});
    bus.sample = 12'sd11;
    tick(1);
    check("t1_above_upper_capture", {29'd0, bus.seq_state}, {29'd0, ST_CAP});
    bus.sample = 12'sd0;
    wait_state(ST_DONE, 20, "t1_reach_done");
    finish_event(20);

    // Falling threshold, arm withdrawn while waiting: no event
    bus.trigtype = 2'd2;
    bus.arm      = 1'b1;
    wait_state(ST_ARM1, 10, "t2_reach_arm1");
    bus.arm = 1'b0;
    wait_state(ST_IDLE, 6, "t2_disarm_idle");
    check("t2_no_event_counted", {16'd0, bus.eventcount}, 32'd2);
    tick(4);

    // External edge: a level held from arm time is ignored, a fresh edge fires
    bus.trigtype     = 2'd3;
    bus.lengthtotake = 16'd3;
    bus.ext_trig     = 1'b1;
    expect_event(3, 3, 0);
    bus.arm = 1'b1;
    wait_state(ST_ARM1, 10, "t3_reach_arm1");
    tick(10);
    check("t3_held_ext_no_trigger", {29'd0, bus.seq_state}, {29'd0, ST_ARM1});
    bus.ext_trig = 1'b0;
    tick(2);
    bus.ext_trig = 1'b1;
    tick(1);
    check("t3_capture_after_edge", {29'd0, bus.seq_state}, {29'd0, ST_CAP});
    check("t3_wr_low_edge_plus1", {31'd0, bus.fifo_wr}, 32'd0);
    tick(1);
    check("t3_wr_high_edge_plus2", {31'd0, bus.fifo_wr}, 32'd1);
    bus.ext_trig = 1'b0;
    wait_state(ST_DONE, 20, "t3_reach_done");
    finish_event(20);

    // FIFO full after the 20th of 50 words
    bus.trigtype     = 2'd0;
    bus.lengthtotake = 16'd50;
    expect_event(20, 4, 1);
    bus.arm = 1'b1;
    n = 0;
    k = 0;
    while (n < 20 && k < 200) begin
      tick(1);
      k++;
      if (bus.fifo_wr === 1'b1) n++;
    end
    bus.fifo_wrfull = 1'b1;
    wait_state(ST_DONE, 10, "t4_reach_done");
    bus.fifo_wrfull = 1'b0;
    finish_event(20);

    // Zero length: one CAPTURE cycle, no strobes, still counted
    bus.lengthtotake = 16'd0;
    expect_event(0, 5, 0);
    bus.arm = 1'b1;
    wait_state(ST_DONE, 20, "t5_reach_done");
    finish_event(20);

    // Holdoff 30 with arm held high throughout
    bus.lengthtotake = 16'd2;
    bus.holdoff      = 16'd30;
    expect_event(2, 6, 0);
    expect_event(2, 7, 0);
    bus.arm = 1'b1;
    wait_state(ST_DONE, 20, "t6_reach_done");
    tick(2);
    bus.readout_done = 1'b1;
    r_cyc = cyc;
    wait_state(ST_HOLD, 10, "t6_reach_holdoff");
    check("t6_holdoff_entry_latency", cyc - r_cyc, 32'd3);
    wait_state(ST_IDLE, 60, "t6_holdoff_to_idle");
    check("t6_holdoff_exit_latency", cyc - r_cyc, 32'd33);
    tick(10);
    check("t6_stale_readout_blocks_arm", {29'd0, bus.seq_state}, {29'd0, ST_IDLE});
    bus.readout_done = 1'b0;
    d_cyc = cyc;
    wait_state(ST_CAP, 10, "t6_recapture");
    check("t6_recapture_latency", cyc - d_cyc, 32'd3);
    wait_state(ST_DONE, 20, "t6_second_done");
    finish_event(80);

    // Asynchronous reset in the middle of a capture
    bus.holdoff      = 16'd0;
    bus.lengthtotake = 16'd100;
    bus.arm          = 1'b1;
    wait_state(ST_CAP, 10, "t7_reach_capture");
    tick(10);
    check("t7_writing_before_reset", {31'd0, bus.fifo_wr}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("t7_async_fifo_wr", {31'd0, bus.fifo_wr}, 32'd0);
    check("t7_async_wordcount", {16'd0, bus.wordcount}, 32'd0);
    check("t7_async_eventcount", {16'd0, bus.eventcount}, 32'd0);
    check("t7_async_state", {29'd0, bus.seq_state}, 32'd0);
    bus.arm = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick(2);

`ifdef TRIG_TIMEOUT_EN
    // Auto trigger after the 4-bit timeout counter saturates
    bus.trigtype     = 2'd1;
    bus.lowerthresh  = -12'sd10;
    bus.upperthresh  = 12'sd10;
    bus.sample       = 12'sd0;
    bus.lengthtotake = 16'd1;
    expect_event(1, 1, 0);
    bus.arm = 1'b1;
    wait_state(ST_ARM1, 10, "t8_reach_arm1");
    d_cyc = cyc;
    wait_state(ST_CAP, 40, "t8_auto_capture");
    check("t8_auto_capture_latency", cyc - d_cyc, 32'd16);
    wait_state(ST_DONE, 10, "t8_reach_done");
    finish_event(20);
`endif

    tick(5);
    check("events_all_seen", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acq_trigger_sequencer.md
# acq_trigger_sequencer

Sequences one acquisition in the clklvds domain: waits for arm, evaluates the selected trigger condition, drives write strobes into the sample FIFO for a programmed number of words, then holds the event until readout completes and an optional holdoff expires. Sits between the command processor's configuration registers (clk domain) and the 560-bit sample FIFO write port. Replaces ad-hoc acquisition logic so trigger type, length and holdoff are decoded and counted in one place.

## Interface
Parameters:
- SYNC_STAGES, 2, flip-flop stages on arm and readout_done inputs (min 2)
- TIMEOUT_W, 24, width of auto-trigger timeout counter (used only with macro)

Ports:
- clklvds  in  1  sample-rate/2 clock; all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- arm  in  1  level from clk domain; request a new event
- readout_done  in  1  level from clk domain; host has read the event
- trigtype  in  2  0 immediate, 1 rising threshold, 2 falling threshold, 3 external edge
- lowerthresh  in  12  signed
- upperthresh  in  12  signed
- lengthtotake  in  16  FIFO words to write per event
- holdoff  in  16  clklvds cycles between readout_done and next arm acceptance
- sample  in  12  signed, trigger-channel sample, already registered
- ext_trig  in  1  external trigger, synchronous to clklvds
- fifo_wrfull  in  1  FIFO write-side full
- fifo_wr  out  1  FIFO write strobe
- wordcount  out  16  words written in current/last event
- eventcount  out  16  completed events, wraps at 65535→0
- event_ready  out  1  event captured, awaiting readout
- truncated  out  1  last event stopped early by fifo_wrfull
- seq_state  out  3  current state, for debug bus

## Operation
- Config inputs sampled only on IDLE→ARM1/CAPTURE transition and held internally for the event.
- States: IDLE(0), ARM1(1), ARM2(2), CAPTURE(3), DONE(4), HOLDOFF(5); 6/7 → IDLE next cycle.
- IDLE: wordcount←0, truncated←0. On synced arm=1: trigtype 0 → CAPTURE; else → ARM1.
- ARM1: type1 sample<lowerthresh → ARM2; type2 sample>upperthresh → ARM2; type3 rising edge of ext_trig (registered edge detect) → CAPTURE directly.
- ARM2: type1 sample>upperthresh → CAPTURE; type2 sample<lowerthresh → CAPTURE.
- arm deasserted in ARM1/ARM2 → IDLE, no event counted.
- CAPTURE: if wordcount<length and !fifo_wrfull: fifo_wr←1, wordcount+1. If wordcount==length: fifo_wr←0, eventcount+1, → DONE. If fifo_wrfull with wordcount<length: fifo_wr←0, truncated←1, eventcount+1, → DONE.
- length 0: CAPTURE lasts one cycle, no fifo_wr, eventcount+1.
- DONE: event_ready=1; wordcount holds; on synced readout_done=1 → HOLDOFF (holdoff 0 → IDLE directly).
- HOLDOFF: count to holdoff, then IDLE; arm ignored until IDLE. IDLE additionally requires synced readout_done=0 before accepting arm (prevents double capture on stale level).
- Comparisons are signed 12-bit, strict (< and >); equality never triggers.

## Timing
- Reset: fifo_wr 0, wordcount 0, eventcount 0, event_ready 0, truncated 0, seq_state 0, sync chains 0; reset mid-CAPTURE drops fifo_wr asynchronously.
- arm/readout_done latency: SYNC_STAGES cycles before visible.
- Trigger sample at edge N → CAPTURE at N+1 → first fifo_wr high at N+2; FIFO data path must be delayed 2 cycles from sample to align.
- fifo_wr registered; high for exactly length consecutive cycles absent full.
- fifo_wrfull and last word same cycle: last word not written, truncated=1.
- event_ready asserts the cycle after entering DONE; deasserts on leaving DONE.

## Configuration
- TRIG_TIMEOUT_EN defined: in ARM1/ARM2 a TIMEOUT_W-bit counter runs; at all-ones forces CAPTURE (auto trigger), counter clears on leaving ARM states.
- Not defined: no counter; ARM states wait indefinitely.

## Test plan
- trigtype 0, length 100, arm 1 → fifo_wr 100 consecutive cycles, eventcount 1, event_ready 1, truncated 0.
- trigtype 1, lower −10, upper 10, sample −11 then 11 → CAPTURE; sample −10 then 10 → stays ARM1.
- trigtype 3, ext_trig pulse during ARM1 → fifo_wr starts 2 cycles after edge; ext_trig held high from arm → no trigger.
- length 50, fifo_wrfull at word 20 → 20 writes, truncated 1, wordcount 20.
- holdoff 30, readout_done with arm held high → next capture ≥30 cycles plus sync after readout_done, only after readout_done drops.
- rstn low mid-CAPTURE → fifo_wr 0 immediately, all counters 0; with TRIG_TIMEOUT_EN, TIMEOUT_W 4 → auto capture 15 cycles into ARM1.
